// File: rtl/encoder83_sync.sv
// encoder83_sync: 8-to-3 priority encoder for asynchronous select lines.
// The lines are synchronized, optionally debounced, and the lowest active
// line is presented as a held code until the consumer acknowledges it.
// Only one code is issued per press: all lines must go inactive before
// another code can be accepted.
// Optional feature: define ENCODER83_DEBOUNCE_EN to compile in the
// DEBOUNCE state (snapshot + stability counter, length DEB_CYCLES).
// Without it, a code is accepted on the first synchronized active sample.
module encoder83_sync #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_y,
    input  logic       i_opt,
    input  logic       i_ack,
    output logic [2:0] o_sel,
    output logic       o_valid,
    output logic       o_multi
);

    // Reject out-of-range debounce lengths at elaboration time
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb_cycles
        $error("encoder83_sync: DEB_CYCLES must be in 1..255");
    end

    localparam logic [1:0] IDLE     = 2'd0;
`ifdef ENCODER83_DEBOUNCE_EN
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
`endif
    localparam logic [1:0] VALID    = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something.
    function automatic logic more_than_one(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    logic [7:0] sync_p0;
    logic [7:0] sync_p1;
    logic [7:0] act;
    logic [1:0] state;
`ifdef ENCODER83_DEBOUNCE_EN
    logic [7:0] snapshot;
    logic [7:0] cnt;
`endif

    // Two-flop synchronizer; reset loads the "all lines inactive" level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_p0 <= {8{~i_opt}};
            sync_p1 <= {8{~i_opt}};
        end else begin
            sync_p0 <= i_y;
            sync_p1 <= sync_p0;
        end
    end

    // Normalize polarity so a set bit always means "line active"
    always_comb begin
        act = i_opt ? sync_p1 : ~sync_p1;
    end

    // Accept / hold / release state machine and the presented code
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_sel    <= 3'd0;
            o_multi  <= 1'b0;
`ifdef ENCODER83_DEBOUNCE_EN
            snapshot <= 8'd0;
            cnt      <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (act != 8'd0) begin
`ifdef ENCODER83_DEBOUNCE_EN
                        state    <= DEBOUNCE;
                        snapshot <= act;
                        cnt      <= 8'd0;
`else
                        state    <= VALID;
                        o_valid  <= 1'b1;
                        o_sel    <= lowest_index(act);
                        o_multi  <= more_than_one(act);
`endif
                    end
                end
`ifdef ENCODER83_DEBOUNCE_EN
                DEBOUNCE: begin
                    if (act == 8'd0) begin
                        state <= IDLE;
                    end else if (act != snapshot) begin
                        // Pattern still moving: restart the stability count
                        snapshot <= act;
                        cnt      <= 8'd0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= VALID;
                        o_valid <= 1'b1;
                        o_sel   <= lowest_index(snapshot);
                        o_multi <= more_than_one(snapshot);
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                VALID: begin
                    // Code stays frozen until acknowledged, whatever the lines do
                    if (i_ack) begin
                        state   <= RELEASE;
                        o_valid <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (act == 8'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder83_sync.sv
// tb_encoder83_sync: directed self-checking bench for encoder83_sync.
// Adapts its expected latency to whether ENCODER83_DEBOUNCE_EN is defined.
module tb_encoder83_sync;

    localparam int DEB = 4;
`ifdef ENCODER83_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_y;
    logic       i_opt;
    logic       i_ack;
    logic [2:0] o_sel;
    logic       o_valid;
    logic       o_multi;

    int n_vec = 0;
    int n_err = 0;

    encoder83_sync #(.DEB_CYCLES(DEB)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_y     (i_y),
        .i_opt   (i_opt),
        .i_ack   (i_ack),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_multi (o_multi)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling/driving
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic v, input logic [2:0] s, input logic m);
        check({tag, "_valid"}, {7'd0, o_valid}, {7'd0, v});
        check({tag, "_sel"},   {5'd0, o_sel},   {5'd0, s});
        check({tag, "_multi"}, {7'd0, o_multi}, {7'd0, m});
    endtask

    task automatic do_reset(input logic opt);
        i_rst = 1'b1;
        i_opt = opt;
        i_y   = opt ? 8'h00 : 8'hFF;
        i_ack = 1'b0;
        tick();
        i_rst = 1'b0;
        outs("reset", 1'b0, 3'd0, 1'b0);
    endtask

    // Apply a pattern and expect o_valid exactly LAT edges later
    task automatic accept(input string tag, input logic [7:0] y, input logic [2:0] s, input logic m);
        i_y = y;
        for (int k = 1; k < LAT; k++) begin
            tick();
            check({tag, "_early"}, {7'd0, o_valid}, 8'd0);
        end
        tick();
        outs(tag, 1'b1, s, m);
    endtask

    // One-cycle acknowledge; code must be retained with o_valid dropped
    task automatic ack_pulse(input string tag, input logic [2:0] s, input logic m);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        outs(tag, 1'b0, s, m);
    endtask

    // Drive all lines inactive long enough for the FSM to see it and go IDLE
    task automatic release_lines(input logic [7:0] inactive);
        i_y = inactive;
        repeat (3) tick();
    endtask

    initial begin
        i_rst = 1'b1;
        i_opt = 1'b0;
        i_y   = 8'hFF;
        i_ack = 1'b0;
        tick();

        // Active-low lines
        do_reset(1'b0);

        // Acknowledge held before acceptance only takes effect once VALID
        i_ack = 1'b1;
        accept("line0_ack_early", 8'hFE, 3'd0, 1'b0);
        tick();
        outs("line0_acked", 1'b0, 3'd0, 1'b0);
        i_ack = 1'b0;

        // Lines still held: no second code for the same press
        repeat (4) tick();
        check("held_no_reissue", {7'd0, o_valid}, 8'd0);
        release_lines(8'hFF);

        accept("line3", 8'hF7, 3'd3, 1'b0);
        ack_pulse("line3_ack", 3'd3, 1'b0);
        release_lines(8'hFF);

        // Lines 1,3,6 active
        accept("multi_b5", 8'hB5, 3'd1, 1'b1);
        ack_pulse("multi_b5_ack", 3'd1, 1'b1);
        repeat (5) tick();
        check("multi_held_no_reissue", {7'd0, o_valid}, 8'd0);
        release_lines(8'hFF);
        accept("line4_after_release", 8'hEF, 3'd4, 1'b0);
        ack_pulse("line4_ack", 3'd4, 1'b0);
        release_lines(8'hFF);

        // Code frozen in VALID while lines change, then reset discards it
        accept("line2", 8'hFB, 3'd2, 1'b0);
        i_y = 8'h7F;
        repeat (4) tick();
        outs("frozen", 1'b1, 3'd2, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        outs("rst_in_valid", 1'b0, 3'd0, 1'b0);
        accept("line7_after_rst", 8'h7F, 3'd7, 1'b0);
        ack_pulse("line7_ack", 3'd7, 1'b0);

        // Active-high lines
        do_reset(1'b1);
        accept("hi_line5", 8'h20, 3'd5, 1'b0);
        ack_pulse("hi_line5_ack", 3'd5, 1'b0);
        release_lines(8'h00);
        accept("hi_multi", 8'hA0, 3'd5, 1'b1);
        ack_pulse("hi_multi_ack", 3'd5, 1'b1);
        release_lines(8'h00);

`ifdef ENCODER83_DEBOUNCE_EN
        // Bouncing line never stays stable long enough to be accepted
        for (int p = 0; p < 5; p++) begin
            i_y = 8'h20;
            repeat (2) tick();
            check("bounce_hi", {7'd0, o_valid}, 8'd0);
            i_y = 8'h00;
            repeat (2) tick();
            check("bounce_lo", {7'd0, o_valid}, 8'd0);
        end
        accept("bounce_settled", 8'h20, 3'd5, 1'b0);
        ack_pulse("bounce_ack", 3'd5, 1'b0);
        release_lines(8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
